// File: rtl/aurora_reset_sequencer.sv
// Purpose: sequences GT_RESET / AURORA_RESET for a 1-lane Aurora 8b10b link and re-runs on link loss.
// Latency: all outputs registered; they change on the same USER_CLK edge as STATE. PLL lock sees 2 sync cycles.
// Backpressure: none; it observes PLL_NOT_LOCKED / CHANNEL_UP / HARD_ERR every cycle and never stalls.
//
// Ports:
//   USER_CLK        sole clock
//   RESET           synchronous active-high reset
//   PLL_NOT_LOCKED  asynchronous, high = GT PLL unlocked (synchronized internally)
//   CHANNEL_UP      Aurora channel up
//   HARD_ERR        Aurora hard error
//   GT_RESET        to core GT_RESET
//   AURORA_RESET    to core RESET
//   LINK_READY      high only while the link is up
//   STATE           current state encoding
//   RETRY_COUNT     saturating count of link re-sequences
module aurora_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int GT_RESET_CYCLES    = 128,
    parameter int SYS_RESET_CYCLES   = 64,
    parameter int UP_TIMEOUT_CYCLES  = 1048576,
    parameter int CNT_WIDTH          = 24,
    parameter int RETRY_WIDTH        = 8
) (
    input  logic                   USER_CLK,
    input  logic                   RESET,
    input  logic                   PLL_NOT_LOCKED,
    input  logic                   CHANNEL_UP,
    input  logic                   HARD_ERR,
    output logic                   GT_RESET,
    output logic                   AURORA_RESET,
    output logic                   LINK_READY,
    output logic [2:0]             STATE,
    output logic [RETRY_WIDTH-1:0] RETRY_COUNT
);

    typedef enum logic [2:0] {
        S_LOCKWAIT = 3'd0,
        S_GTRST    = 3'd1,
        S_SYSRST   = 3'd2,
        S_WAITUP   = 3'd3,
        S_UP       = 3'd4
    } state_t;

    // A dwell of N cycles ends when the counter reaches N-1.
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GT_LAST   = CNT_WIDTH'(GT_RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SYS_LAST  = CNT_WIDTH'(SYS_RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] UP_LAST   = CNT_WIDTH'(UP_TIMEOUT_CYCLES - 1);

    logic                   nl_meta_q, nl_meta_d;
    logic                   nl_s_q, nl_s_d;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [RETRY_WIDTH-1:0] retry_q, retry_d;
    logic                   gt_reset_q, gt_reset_d;
    logic                   aurora_reset_q, aurora_reset_d;
    logic                   link_ready_q, link_ready_d;
    logic                   retry_inc;

    always_comb begin
        nl_meta_d = PLL_NOT_LOCKED;
        nl_s_d    = nl_meta_q;
        state_d   = state_q;
        retry_inc = 1'b0;

        case (state_q)
            S_LOCKWAIT: if (!nl_s_q && cnt_q == LOCK_LAST) state_d = S_GTRST;
            S_GTRST:    if (cnt_q == GT_LAST)  state_d = S_SYSRST;
            S_SYSRST:   if (cnt_q == SYS_LAST) state_d = S_WAITUP;
            S_WAITUP: begin
                // Channel coming up in the timeout cycle still counts as success.
                if (CHANNEL_UP) begin
                    state_d = S_UP;
                end else if (cnt_q == UP_LAST) begin
                    state_d   = S_GTRST;
                    retry_inc = 1'b1;
                end
            end
            S_UP: begin
                if (!CHANNEL_UP || HARD_ERR) begin
                    state_d   = S_SYSRST;
                    retry_inc = 1'b1;
                end
            end
            default: state_d = S_LOCKWAIT;
        endcase

        // Losing PLL lock trumps everything and is not a link retry.
        if (nl_s_q && state_q != S_LOCKWAIT) begin
            state_d   = S_LOCKWAIT;
            retry_inc = 1'b0;
        end

        // Counter restarts on every state change; in LOCKWAIT any unlocked
        // cycle also restarts the stability count.
        if (state_d != state_q || (state_q == S_LOCKWAIT && nl_s_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end

        retry_d = (retry_inc && retry_q != '1) ? retry_q + RETRY_WIDTH'(1) : retry_q;

        // Outputs decoded from the next state so they register alongside it.
        gt_reset_d     = 1'b1;
        aurora_reset_d = 1'b1;
        link_ready_d   = 1'b0;
        case (state_d)
            S_SYSRST: gt_reset_d = 1'b0;
            S_WAITUP: begin
                gt_reset_d     = 1'b0;
                aurora_reset_d = 1'b0;
            end
            S_UP: begin
                gt_reset_d     = 1'b0;
                aurora_reset_d = 1'b0;
                link_ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            nl_meta_q      <= 1'b1;
            nl_s_q         <= 1'b1;
            state_q        <= S_LOCKWAIT;
            cnt_q          <= '0;
            retry_q        <= '0;
            gt_reset_q     <= 1'b1;
            aurora_reset_q <= 1'b1;
            link_ready_q   <= 1'b0;
        end else begin
            nl_meta_q      <= nl_meta_d;
            nl_s_q         <= nl_s_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            gt_reset_q     <= gt_reset_d;
            aurora_reset_q <= aurora_reset_d;
            link_ready_q   <= link_ready_d;
        end
    end

    assign GT_RESET     = gt_reset_q;
    assign AURORA_RESET = aurora_reset_q;
    assign LINK_READY   = link_ready_q;
    assign STATE        = state_q;
    assign RETRY_COUNT  = retry_q;

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// Purpose: directed self-checking bench for aurora_reset_sequencer.
// Latency: expectations are pushed before advancing and popped after the edge they describe.
// Backpressure: n/a.
module tb_aurora_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_not_locked;
    logic       channel_up;
    logic       hard_err;
    logic       gt_reset;
    logic       aurora_reset;
    logic       link_ready;
    logic [2:0] state;
    logic [7:0] retry_count;

    aurora_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .GT_RESET_CYCLES    (4),
        .SYS_RESET_CYCLES   (4),
        .UP_TIMEOUT_CYCLES  (32),
        .CNT_WIDTH          (24),
        .RETRY_WIDTH        (8)
    ) dut (
        .USER_CLK       (clk),
        .RESET          (rst),
        .PLL_NOT_LOCKED (pll_not_locked),
        .CHANNEL_UP     (channel_up),
        .HARD_ERR       (hard_err),
        .GT_RESET       (gt_reset),
        .AURORA_RESET   (aurora_reset),
        .LINK_READY     (link_ready),
        .STATE          (state),
        .RETRY_COUNT    (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rc_exp;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic sb_push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h required=an_entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s @cycle %0d observed=%0h required=%0h", t, cyc, obs, e);
            end
        end
    endtask

    task automatic exp_outs(input string t, input int st, input int gt, input int au,
                            input int lr, input int rc);
        sb_push({t, ".state"},        32'(st));
        sb_push({t, ".gt_reset"},     32'(gt));
        sb_push({t, ".aurora_reset"}, 32'(au));
        sb_push({t, ".link_ready"},   32'(lr));
        sb_push({t, ".retry_count"},  32'(rc));
    endtask

    task automatic chk_outs();
        sb_check(32'(state));
        sb_check(32'(gt_reset));
        sb_check(32'(aurora_reset));
        sb_check(32'(link_ready));
        sb_check(32'(retry_count));
    endtask

    initial begin
        rst            = 1'b1;
        pll_not_locked = 1'b1;
        channel_up     = 1'b0;
        hard_err       = 1'b0;

        // Power-up: reset for 3 cycles, lock at cycle 10.
        exp_outs("reset", 0, 1, 1, 0, 0);           step(1);  chk_outs(); // 1
        step(2); rst = 1'b0;                                                // 3
        step(7); pll_not_locked = 1'b0;                                     // 10
        exp_outs("lockwait_end", 0, 1, 1, 0, 0);    step(9);  chk_outs(); // 19
        exp_outs("gtrst_entry", 1, 1, 1, 0, 0);     step(1);  chk_outs(); // 20
        exp_outs("gtrst_last", 1, 1, 1, 0, 0);      step(3);  chk_outs(); // 23
        exp_outs("sysrst_entry", 2, 0, 1, 0, 0);    step(1);  chk_outs(); // 24
        exp_outs("sysrst_last", 2, 0, 1, 0, 0);     step(3);  chk_outs(); // 27
        exp_outs("waitup_entry", 3, 0, 0, 0, 0);    step(1);  chk_outs(); // 28

        // Channel up, then a one-cycle hard error.
        exp_outs("waitup_hold", 3, 0, 0, 0, 0);     step(2);  chk_outs(); // 30
        channel_up = 1'b1;
        exp_outs("link_up", 4, 0, 0, 1, 0);         step(1);  chk_outs(); // 31
        step(2); hard_err = 1'b1;                                           // 33
        exp_outs("hard_err_sysrst", 2, 0, 1, 0, 1); step(1);  chk_outs(); // 34
        hard_err = 1'b0;
        exp_outs("hard_err_sysrst_last", 2, 0, 1, 0, 1); step(3); chk_outs(); // 37
        exp_outs("rewaitup", 3, 0, 0, 0, 1);        step(1);  chk_outs(); // 38
        exp_outs("relink_up", 4, 0, 0, 1, 1);       step(1);  chk_outs(); // 39

        // Lock loss in S_UP coinciding with a hard error.
        step(2); pll_not_locked = 1'b1;                                     // 41
        exp_outs("up_before_sync", 4, 0, 0, 1, 1);  step(2);  chk_outs(); // 43
        hard_err = 1'b1;
        exp_outs("lock_loss", 0, 1, 1, 0, 1);       step(1);  chk_outs(); // 44
        hard_err   = 1'b0;
        channel_up = 1'b0;

        // Relock with a one-cycle glitch in the middle of the stability count.
        step(1); pll_not_locked = 1'b0;                                     // 45
        step(6); pll_not_locked = 1'b1;                                     // 51
        step(1); pll_not_locked = 1'b0;                                     // 52
        exp_outs("glitch_no_early", 0, 1, 1, 0, 1); step(3);  chk_outs(); // 55
        exp_outs("glitch_count", 0, 1, 1, 0, 1);    step(6);  chk_outs(); // 61
        exp_outs("glitch_gtrst", 1, 1, 1, 0, 1);    step(1);  chk_outs(); // 62

        // Channel-up timeout.
        exp_outs("to_waitup", 3, 0, 0, 0, 1);       step(8);  chk_outs(); // 70
        exp_outs("to_waitup_last", 3, 0, 0, 0, 1);  step(31); chk_outs(); // 101
        rc_exp = 2;
        exp_outs("timeout_retry", 1, 1, 1, 0, rc_exp); step(1); chk_outs(); // 102

        for (int i = 0; i < 300; i++) begin
            if (rc_exp < 255) rc_exp++;
            exp_outs("timeout_loop", 1, 1, 1, 0, rc_exp);
            step(40);
            chk_outs();
        end
        sb_push("retry_saturated", 32'd255);
        sb_check(32'(retry_count));

        // Channel drop while up, with the retry count saturated.
        exp_outs("sat_waitup", 3, 0, 0, 0, 255);    step(8);  chk_outs();
        channel_up = 1'b1;
        exp_outs("sat_up", 4, 0, 0, 1, 255);        step(1);  chk_outs();
        channel_up = 1'b0;
        exp_outs("chan_drop", 2, 0, 1, 0, 255);     step(1);  chk_outs();
        channel_up = 1'b1;
        exp_outs("chan_drop_waitup", 3, 0, 0, 0, 255); step(4); chk_outs();
        exp_outs("chan_drop_up", 4, 0, 0, 1, 255);  step(1);  chk_outs();

        // Reset while up.
        rst = 1'b1;
        exp_outs("reset_in_up", 0, 1, 1, 0, 0);     step(1);  chk_outs();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
